// File: rtl/isqrt_pkg.sv
// Shared types and helpers for the pipelined integer square root.
// Producers and consumers can size tag FIFOs from L_OF(W, K).
package isqrt_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  typedef struct packed {
    word_t x;
    word_t y;
  } xy_t;

  // Number of one-bit-of-root slices for a W-bit radicand.
  function automatic int N_OF(input int w);
    return w / 2;
  endfunction

  // Number of register stages (= latency in cycles) with k slices per stage.
  function automatic int L_OF(input int w, input int k);
    return (w / 2 + k - 1) / k;
  endfunction

  // One restoring step of the digit-by-digit square root.
  // m is the current trial bit; x is the running remainder, y the running root.
  function automatic xy_t isqrt_slice_step(input word_t x, input word_t y, input word_t m);
    xy_t   res;
    word_t b;
    b     = y | m;
    res.y = y >> 1;
    res.x = x;
    if (x >= b) begin
      res.x = x - b;
      res.y = res.y | m;
    end
    return res;
  endfunction

endpackage

// File: rtl/isqrt_pipe_hs_if.sv
// Valid/ready operand and result streams of the isqrt pipeline.
// master = producer/consumer side, slave = the pipeline itself.
interface isqrt_pipe_hs_if #(
  parameter int W     = 32,
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W/2-1:0]   out_y;
  logic [W/2:0]     out_r;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_x, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_r, out_tag
  );

  modport slave (
    input  in_valid, in_x, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_r, out_tag
  );

endinterface

// File: rtl/isqrt_stage.sv
// One pipeline stage: K_THIS chained root slices starting at FIRST_SLICE,
// followed by a register that loads whenever the top asserts ld.
module isqrt_stage
  import isqrt_pkg::*;
#(
  parameter int W           = 32,
  parameter int K_THIS      = 2,
  parameter int FIRST_SLICE = 0,
  parameter int TAG_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ld,
  input  logic             v_in,
  input  logic [W-1:0]     x_in,
  input  logic [W-1:0]     y_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             v_q,
  output logic [W-1:0]     x_q,
  output logic [W-1:0]     y_q,
  output logic [TAG_W-1:0] tag_q
);

  word_t x_c;
  word_t y_c;
  xy_t   step;

  // Chain this stage's slices; trial bit of slice j is 1 << (W-2-2j).
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so each slice sees the previous slice's result.
    // NOTE: every variable gets a value before the loop so no path can infer a latch.
    step = '0;
    x_c  = word_t'(x_in);
    y_c  = word_t'(y_in);
    for (int i = 0; i < K_THIS; i++) begin
      step = isqrt_slice_step(x_c, y_c, word_t'(1) << (W - 2 - 2 * (FIRST_SLICE + i)));
      x_c  = step.x;
      y_c  = step.y;
    end
  end

  // Stage register: valid always follows on load, data only when a real operand arrives.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential blocks use non-blocking '<=' so all stages update from pre-edge values.
    if (reset) begin
      // NOTE: data registers are reset too, so outputs read as zero after reset, not stale data.
      v_q   <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      tag_q <= '0;
    end else if (ld) begin
      v_q <= v_in;
      if (v_in) begin
        x_q   <= x_c[W-1:0];
        y_q   <= y_c[W-1:0];
        tag_q <= tag_in;
      end
    end
  end

endmodule

// File: rtl/isqrt_pipe_hs.sv
// Pipelined unsigned integer square root with valid/ready backpressure:
// out_y = floor(sqrt(in_x)), out_r = in_x - out_y^2, out_tag = in_tag.
// L = ceil((W/2)/K) stages; empty stages always load so bubbles collapse.
module isqrt_pipe_hs
  import isqrt_pkg::*;
#(
  parameter int W     = 32,
  parameter int K     = 2,
  parameter int TAG_W = 4
) (
  input  logic         clock,
  input  logic         reset,
  isqrt_pipe_hs_if.slave bus
);

  localparam int N = N_OF(W);
  localparam int L = L_OF(W, K);

  if ((W % 2) != 0 || W < 4 || W > MAX_W) begin : g_bad_w
    $error("isqrt_pipe_hs: W must be even and within 4..64");
  end
  if (K < 1 || K > N) begin : g_bad_k
    $error("isqrt_pipe_hs: K must be within 1..W/2");
  end

  // Index s is the input of stage s; index s+1 is its registered output.
  logic [L:0]       v_s;
  logic [W-1:0]     x_s   [L+1];
  logic [W-1:0]     y_s   [L+1];
  logic [TAG_W-1:0] tag_s [L+1];
  // ld[s] loads stage s; ld[L] is the consumer's ready.
  logic [L:0]       ld;

  assign v_s[0]   = bus.in_valid;
  assign x_s[0]   = bus.in_x;
  assign y_s[0]   = '0;
  assign tag_s[0] = bus.in_tag;

  // Ready chain from the consumer back to the producer: a stage loads if it
  // is empty or its contents move on this cycle.
  always_comb begin
    ld    = '0;
    ld[L] = bus.out_ready;
    for (int s = L - 1; s >= 0; s--) begin
      ld[s] = ~v_s[s+1] | ld[s+1];
    end
  end

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int FIRST = s * K;
    localparam int KT    = (N - FIRST < K) ? (N - FIRST) : K;

    isqrt_stage #(
      .W           (W),
      .K_THIS      (KT),
      .FIRST_SLICE (FIRST),
      .TAG_W       (TAG_W)
    ) u_stage (
      .clock  (clock),
      .reset  (reset),
      .ld     (ld[s]),
      .v_in   (v_s[s]),
      .x_in   (x_s[s]),
      .y_in   (y_s[s]),
      .tag_in (tag_s[s]),
      .v_q    (v_s[s+1]),
      .x_q    (x_s[s+1]),
      .y_q    (y_s[s+1]),
      .tag_q  (tag_s[s+1])
    );
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = v_s[L];
  assign bus.out_y     = y_s[L][W/2-1:0];
  assign bus.out_r     = x_s[L][W/2:0];
  assign bus.out_tag   = tag_s[L];

  // The root never exceeds W/2 bits and the remainder never exceeds W/2+1 bits,
  // so the upper bits of the final stage are always zero.
  logic unused_hi;
  assign unused_hi = ^{x_s[L][W-1:W/2+1], y_s[L][W-1:W/2]};

endmodule
